// File: rtl/bus_frame_comparator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_cmp_pkg
//  Description : Shared constants for the dual-channel bus frame comparator:
//                FSM state encodings, status encodings and the status update
//                rule applied when a comparison result is produced.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_cmp_pkg;

    // FSM state encodings
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HAVE_A = 3'd1;
    localparam logic [2:0] S_HAVE_B = 3'd2;
    localparam logic [2:0] S_COMP   = 3'd3;
    localparam logic [2:0] S_REPORT = 3'd4;

    // Status output encodings
    localparam logic [1:0] ST_MATCH = 2'b00;
    localparam logic [1:0] ST_MISM  = 2'b01;
    localparam logic [1:0] ST_NONE  = 2'b10;
    localparam logic [1:0] ST_FAULT = 2'b11;

    // Fault is sticky: once raised, only clr/rst can leave it.
    function automatic logic [1:0] next_status(input logic [1:0] cur,
                                               input logic       mism,
                                               input logic       hit_thresh);
        if ((cur == ST_FAULT) || (mism && hit_thresh)) begin
            return ST_FAULT;
        end
        return mism ? ST_MISM : ST_MATCH;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_frame_comparator_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_frame_comparator_if
//  Description : Valid/ready frame bus for the redundant A/B channels.
//                master : frame sources (drive valid/data, observe ready)
//                slave  : comparator    (observe valid/data, drive ready)
//  Ports       : a_valid/a_data/a_ready, b_valid/b_data/b_ready
//  Revision    : 1.0 - initial release
// ============================================================================
interface bus_frame_comparator_if #(
    parameter int FRAME_W = 64
);
    logic               a_valid;
    logic [FRAME_W-1:0] a_data;
    logic               a_ready;
    logic               b_valid;
    logic [FRAME_W-1:0] b_data;
    logic               b_ready;

    modport master (
        output a_valid, a_data, b_valid, b_data,
        input  a_ready, b_ready
    );

    modport slave (
        input  a_valid, a_data, b_valid, b_data,
        output a_ready, b_ready
    );
endinterface
`default_nettype wire

// File: rtl/bus_frame_comparator_frame_capture_slot.sv
`default_nettype none
// ============================================================================
//  Module      : frame_capture_slot
//  Description : Single-entry valid/ready capture register for one channel.
//                Stores only the compared field of an accepted frame.
//  Ports       : clk, rst       - clock, sync active-high reset
//                valid_i/data_i - incoming frame
//                en_i           - acceptance window from the controlling FSM
//                release_i      - empties the slot
//                ready_o        - slot can accept a frame this cycle
//                take_o         - frame accepted this cycle
//                field_o        - stored compare field
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_capture_slot #(
    parameter int FRAME_W = 64,
    parameter int CMP_W   = 48,
    parameter int CMP_LSB = 16
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               valid_i,
    input  wire logic [FRAME_W-1:0] data_i,
    input  wire logic               en_i,
    input  wire logic               release_i,
    output logic                    ready_o,
    output logic                    take_o,
    output logic [CMP_W-1:0]        field_o
);

    logic             full_q,  full_d;
    logic [CMP_W-1:0] field_q, field_d;

    // Bits outside the compared field (CRC etc.) are intentionally ignored.
    logic w_unused_data;
    assign w_unused_data = ^data_i;

    assign ready_o = en_i & ~full_q;
    assign take_o  = valid_i & ready_o;
    assign field_o = field_q;

    always_comb begin
        full_d  = full_q;
        field_d = field_q;
        if (release_i) begin
            full_d = 1'b0;
        end
        if (take_o) begin
            full_d  = 1'b1;
            field_d = data_i[CMP_LSB +: CMP_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q  <= 1'b0;
            field_q <= '0;
        end else begin
            full_q  <= full_d;
            field_q <= field_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_frame_comparator.sv
`default_nettype none
// ============================================================================
//  Module      : bus_frame_comparator
//  Description : Dual-channel frame comparator for redundant buses A/B.
//                Captures one frame per channel, compares a field, reports
//                match/mismatch/timeout, counts mismatches (saturating) and
//                raises a sticky fault after FAIL_THRESH consecutive failures.
//  Ports       : clk, rst       - clock, sync active-high reset
//                bus            - A/B valid/ready frame channels (slave)
//                clr            - clears status, counters, timeout flag
//                result_valid   - one-cycle pulse per comparison result
//                status         - 00 match, 01 mismatch, 10 none, 11 fault
//                timeout_err    - last result was a partner timeout
//                mismatch_cnt   - saturating mismatch+timeout count
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_frame_comparator
    import bus_cmp_pkg::*;
#(
    parameter int FRAME_W     = 64,
    parameter int CMP_W       = 48,
    parameter int CMP_LSB     = 16,
    parameter int TIMEOUT     = 255,
    parameter int FAIL_THRESH = 3,
    parameter int CNT_W       = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    bus_frame_comparator_if.slave     bus,
    input  wire logic                 clr,
    output logic                      result_valid,
    output logic [1:0]                status,
    output logic                      timeout_err,
    output logic [CNT_W-1:0]          mismatch_cnt
);

    localparam int TMR_W  = $clog2(TIMEOUT + 1);
    localparam int CONS_W = $clog2(FAIL_THRESH + 1);

    localparam logic [TMR_W-1:0]  TMR_LAST      = TMR_W'(TIMEOUT - 1);
    localparam logic [CONS_W-1:0] CONS_MAX      = CONS_W'(FAIL_THRESH);
    localparam logic [CONS_W-1:0] CONS_LAST_OK  = CONS_W'(FAIL_THRESH - 1);

    generate
        if (CMP_LSB + CMP_W > FRAME_W) begin : g_bad_field
            $error("bus_frame_comparator: CMP_LSB+CMP_W exceeds FRAME_W");
        end
        if (TIMEOUT < 1) begin : g_bad_timeout
            $error("bus_frame_comparator: TIMEOUT must be >= 1");
        end
        if (FAIL_THRESH < 1) begin : g_bad_thresh
            $error("bus_frame_comparator: FAIL_THRESH must be >= 1");
        end
    endgenerate

    logic [2:0]        state_q,  state_d;
    logic [TMR_W-1:0]  timer_q,  timer_d;
    logic [CONS_W-1:0] consec_q, consec_d;
    logic [1:0]        status_q, status_d;
    logic              terr_q,   terr_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;

    logic              w_accept_en;
    logic              w_release;
    logic              w_take_a, w_take_b;
    logic [CMP_W-1:0]  w_field_a, w_field_b;
    logic              w_rep_evt, w_rep_mism, w_rep_tmo;
    logic              w_hit_thresh;

    // Slots only accept while the FSM is collecting frames; this keeps a
    // late partner frame from being swallowed during COMP/REPORT.
    assign w_accept_en = (state_q == S_IDLE) || (state_q == S_HAVE_A) ||
                         (state_q == S_HAVE_B);
    assign w_release   = (state_q == S_REPORT);

    frame_capture_slot #(
        .FRAME_W (FRAME_W),
        .CMP_W   (CMP_W),
        .CMP_LSB (CMP_LSB)
    ) u_slot_a (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (bus.a_valid),
        .data_i    (bus.a_data),
        .en_i      (w_accept_en),
        .release_i (w_release),
        .ready_o   (bus.a_ready),
        .take_o    (w_take_a),
        .field_o   (w_field_a)
    );

    frame_capture_slot #(
        .FRAME_W (FRAME_W),
        .CMP_W   (CMP_W),
        .CMP_LSB (CMP_LSB)
    ) u_slot_b (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (bus.b_valid),
        .data_i    (bus.b_data),
        .en_i      (w_accept_en),
        .release_i (w_release),
        .ready_o   (bus.b_ready),
        .take_o    (w_take_b),
        .field_o   (w_field_b)
    );

    // FSM and partner timer. A result event is raised on the transition into
    // REPORT so status/counters are already updated during the REPORT cycle.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        w_rep_evt  = 1'b0;
        w_rep_mism = 1'b0;
        w_rep_tmo  = 1'b0;
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (w_take_a && w_take_b) begin
                    state_d = S_COMP;
                end else if (w_take_a) begin
                    state_d = S_HAVE_A;
                end else if (w_take_b) begin
                    state_d = S_HAVE_B;
                end
            end
            S_HAVE_A, S_HAVE_B: begin
                // Partner arrival wins over a timeout in the same cycle.
                if ((state_q == S_HAVE_A) ? w_take_b : w_take_a) begin
                    state_d = S_COMP;
                end else if (timer_q == TMR_LAST) begin
                    state_d    = S_REPORT;
                    w_rep_evt  = 1'b1;
                    w_rep_mism = 1'b1;
                    w_rep_tmo  = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_COMP: begin
                state_d    = S_REPORT;
                w_rep_evt  = 1'b1;
                w_rep_mism = (w_field_a != w_field_b);
            end
            S_REPORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // This result is the FAIL_THRESH-th consecutive failure if it fails.
    assign w_hit_thresh = (consec_q >= CONS_LAST_OK);

    always_comb begin
        status_d = status_q;
        terr_d   = terr_q;
        cnt_d    = cnt_q;
        consec_d = consec_q;
        if (clr) begin
            status_d = ST_NONE;
            terr_d   = 1'b0;
            cnt_d    = '0;
            consec_d = '0;
        end else if (w_rep_evt) begin
            terr_d = w_rep_tmo;
            if (w_rep_mism) begin
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (consec_q != CONS_MAX) begin
                    consec_d = consec_q + CONS_W'(1);
                end
            end else begin
                consec_d = '0;
            end
            status_d = next_status(status_q, w_rep_mism, w_hit_thresh);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            consec_q <= '0;
            status_q <= ST_NONE;
            terr_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            consec_q <= consec_d;
            status_q <= status_d;
            terr_q   <= terr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign result_valid = (state_q == S_REPORT);
    assign status       = status_q;
    assign timeout_err  = terr_q;
    assign mismatch_cnt = cnt_q;

endmodule
`default_nettype wire
